cpu_multisim_sink: RTL and testbench
====================================

CPU_MULTISIM_SINK -- requirements
Module: cpu_multisim_sink

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the transaction word; SHALL be 64 (32-bit index field plus 32-bit sequence field).
REQ-002 Parameter FIFO_DEPTH, default 4, number of receive buffer entries; SHALL be a power of two, at least 2.
REQ-003 Parameter N_TRANSACTIONS, default 16, number of transactions consumed before completion.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port cpu_index, input, 32: index expected in data[63:32]; static after reset release.
REQ-007 Port enable, input, 1: starts reception.
REQ-008 Port drain_en, input, 1: permits one FIFO pop per cycle (bench-driven backpressure).
REQ-009 Port data_vld, input, 1: upstream word valid.
REQ-010 Port data_rdy, output, 1: sink can accept a word.
REQ-011 Port data, input, DATA_WIDTH: transaction word.
REQ-012 Port rx_count, output, 32: words popped and checked.
REQ-013 Port error_count, output, 16: check failures, saturating.
REQ-014 Port late_data, output, 1: sticky; data_vld seen in DONE.
REQ-015 Port transactions_done, output, 1: high in DONE.

Function
REQ-016 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-017 IDLE->RUN on first cycle enable=1; RUN->DONE on the cycle rx_count becomes N_TRANSACTIONS; DONE is terminal until reset.
REQ-018 data_rdy = (state==RUN) and FIFO not full, derived from registered FIFO count only.
REQ-019 Push occurs on rising edge with data_vld=1 and data_rdy=1; data held while data_vld=1 and data_rdy=0 is not consumed.
REQ-020 Pushed word visible for pop no earlier than the next cycle (1-cycle minimum latency).
REQ-021 Pop occurs when state==RUN, drain_en=1 and FIFO not empty; one pop per cycle max.
REQ-022 Push and pop in the same cycle SHALL both occur when FIFO is neither full nor empty; when full, data_rdy=0 so no push regardless of pop.
REQ-023 Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
REQ-024 Each pop: index mismatch (data[63:32] != cpu_index) or sequence mismatch (data[31:0] != expected_seq) increments error_count once (even if both fail).
REQ-025 expected_seq starts at 0; after each pop it becomes popped data[31:0]+1 (resynchronizes after error), 32-bit wrap.
REQ-026 rx_count increments by 1 per pop; error_count saturates at 16'hFFFF.
REQ-027 transactions_done is registered, rising the cycle after the final pop; words remaining in FIFO at DONE are discarded uncounted.
REQ-028 In DONE, data_rdy=0; data_vld=1 sets late_data.

Reset
REQ-029 rst asserted asynchronously: state=IDLE, FIFO empty, pointers 0, expected_seq=0, rx_count=0, error_count=0, late_data=0, transactions_done=0, data_rdy=0.
REQ-030 Reset mid-transfer discards FIFO contents; no partial push or pop completes on the reset edge.

Structure
REQ-031 Package cpu_multisim_pkg holds the transaction struct (index[31:0], seq[31:0]), state enum, and DATA_WIDTH constant.
REQ-032 FIFO is a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) sharing clk and rst.

Verification
REQ-033 cpu_index=3, 16 in-order words {3,0..15}, drain_en=1 -> rx_count=16, error_count=0, transactions_done high one cycle after 16th pop.
REQ-034 drain_en=0, data_vld held high -> exactly 4 pushes, data_rdy low from the cycle after the 4th push; drain_en=1 resumes with no loss or duplication.
REQ-035 Sequence 0,1,5,6 with cpu_index=3 -> error_count=1 (at seq 5), no error at seq 6.
REQ-036 Word {7,0} with cpu_index=3 -> error_count=1; next {3,1} -> no error.
REQ-037 rst asserted with 3 words buffered -> all outputs at reset values asynchronously; after enable, sequence restarting at 0 passes clean.
REQ-038 data_vld=1 after transactions_done -> data_rdy=0, late_data=1, rx_count unchanged at 16.

Source files
------------

// File: rtl/cpu_multisim_pkg.sv
// cpu_multisim_pkg
//   Shared definitions for the multi-CPU simulation sink: the transaction
//   word layout (CPU index in the upper half, sequence number in the lower
//   half), the sink FSM state type and the transaction word width.
package cpu_multisim_pkg;

  localparam int DATA_WIDTH = 64;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] seq;
  } txn_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_multisim_sink_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with first-word-fall-through read data. A pushed word
//   becomes poppable on the following cycle because empty/full come from the
//   registered occupancy count.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   push      - write wdata this cycle (ignored when full)
//   pop       - retire the head entry this cycle (ignored when empty)
//   wdata     - word to write
//   rdata     - current head entry
//   full      - DEPTH entries held
//   empty     - no entries held
//   count     - current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the
  // pointers and count return to zero.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cpu_multisim_sink.sv
// cpu_multisim_sink
//   Consumes N_TRANSACTIONS transaction words from one simulated CPU,
//   buffering them in a small FIFO and checking each popped word for the
//   expected CPU index and a contiguous sequence number.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   cpu_index         - index expected in the upper half of every word
//   enable            - starts reception (IDLE -> RUN)
//   drain_en          - allows one FIFO pop per cycle
//   data_vld/data_rdy - upstream valid/ready handshake
//   data              - transaction word {index, seq}
//   rx_count          - words popped and checked
//   error_count       - failed checks, saturating
//   late_data         - sticky, a word was offered after completion
//   transactions_done - high once all transactions were consumed
module cpu_multisim_sink #(
  parameter int DATA_WIDTH     = cpu_multisim_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int N_TRANSACTIONS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_index,
  input  logic                  enable,
  input  logic                  drain_en,
  input  logic                  data_vld,
  output logic                  data_rdy,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [31:0]           rx_count,
  output logic [15:0]           error_count,
  output logic                  late_data,
  output logic                  transactions_done
);

  import cpu_multisim_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [31:0]           exp_seq_q, exp_seq_d;
  logic [31:0]           rx_count_q, rx_count_d;
  logic [15:0]           err_q, err_d;
  logic                  late_q, late_d;
  logic                  done_q, done_d;

  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count_unused;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  push, pop, mismatch;
  txn_t                  head;

  // Ready depends only on registered state and the registered FIFO
  // occupancy, so it never combinationally follows data_vld.
  assign data_rdy = (state_q == ST_RUN) && !fifo_full;
  assign push     = data_vld && data_rdy;
  assign pop      = (state_q == ST_RUN) && drain_en && !fifo_empty;

  assign head     = txn_t'(fifo_rdata);
  // Index and sequence failures on the same word count as one error.
  assign mismatch = (head.index != cpu_index) || (head.seq != exp_seq_q);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  // Next-state logic. The expected sequence follows the popped word rather
  // than the previous expectation, so one bad word produces one error.
  always_comb begin
    state_d    = state_q;
    exp_seq_d  = exp_seq_q;
    rx_count_d = rx_count_q;
    err_d      = err_q;
    late_d     = late_q;
    done_d     = done_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pop) begin
          rx_count_d = rx_count_q + 32'd1;
          exp_seq_d  = head.seq + 32'd1;
          if (mismatch && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
          if (rx_count_q == 32'(N_TRANSACTIONS - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (data_vld) late_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      exp_seq_q  <= '0;
      rx_count_q <= '0;
      err_q      <= '0;
      late_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_seq_q  <= exp_seq_d;
      rx_count_q <= rx_count_d;
      err_q      <= err_d;
      late_q     <= late_d;
      done_q     <= done_d;
    end
  end

  assign rx_count          = rx_count_q;
  assign error_count       = err_q;
  assign late_data         = late_q;
  assign transactions_done = done_q;

endmodule

// File: tb/tb_cpu_multisim_sink.sv
// tb_cpu_multisim_sink
//   Self-checking bench for cpu_multisim_sink. Each accepted word pushes its
//   expected error flag into a scoreboard queue; a monitor pops one entry for
//   every increment of rx_count and checks the running error count and the
//   completion flag.
module tb_cpu_multisim_sink;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_index;
  logic        enable;
  logic        drain_en;
  logic        data_vld;
  logic        data_rdy;
  logic [63:0] data;
  logic [31:0] rx_count;
  logic [15:0] error_count;
  logic        late_data;
  logic        transactions_done;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] seq;
    logic        expErr;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  logic   expQ[$];
  logic   monOn = 1'b0;
  int     lastRx = 0;
  int     expErrCnt = 0;
  vec_t   vecs[8];

  cpu_multisim_sink #(
    .DATA_WIDTH     (64),
    .FIFO_DEPTH     (4),
    .N_TRANSACTIONS (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_index         (cpu_index),
    .enable            (enable),
    .drain_en          (drain_en),
    .data_vld          (data_vld),
    .data_rdy          (data_rdy),
    .data              (data),
    .rx_count          (rx_count),
    .error_count       (error_count),
    .late_data         (late_data),
    .transactions_done (transactions_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Offers one word starting at a falling edge and holds it until ready is
  // seen; the handshake completes on the following rising edge.
  task automatic applyStimulus(input logic [31:0] idx, input logic [31:0] seq, input logic expErr);
    int waitCycles = 0;
    data     = {idx, seq};
    data_vld = 1'b1;
    while (!data_rdy && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!data_rdy) begin
      checkOutput("handshakeTimeout", 32'd0, 32'd1);
      data_vld = 1'b0;
      return;
    end
    expQ.push_back(expErr);
    @(negedge clk);
    data_vld = 1'b0;
  endtask

  task automatic waitRx(input int target);
    int n = 0;
    while (rx_count != 32'(target) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitRx", rx_count, 32'(target));
  endtask

  // Asserts reset mid-cycle and checks that outputs clear before any edge.
  task automatic doReset();
    monOn = 1'b0;
    enable = 1'b0;
    data_vld = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstRx", rx_count, 32'd0);
    checkOutput("rstErr", 32'(error_count), 32'd0);
    checkOutput("rstLate", 32'(late_data), 32'd0);
    checkOutput("rstDone", 32'(transactions_done), 32'd0);
    checkOutput("rstRdy", 32'(data_rdy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    lastRx = 0;
    expErrCnt = 0;
    monOn = 1'b1;
  endtask

  // Scoreboard monitor: every rx_count step retires one expected entry.
  always @(negedge clk) begin
    if (monOn && rx_count != 32'(lastRx)) begin
      checkOutput("rxStep", rx_count, 32'(lastRx + 1));
      if (expQ.size() == 0) begin
        checkOutput("sbUnderflow", 32'd1, 32'd0);
      end else begin
        if (expQ.pop_front() && expErrCnt != 16'hFFFF) expErrCnt++;
      end
      checkOutput("errCount", 32'(error_count), 32'(expErrCnt));
      checkOutput("doneFlag", 32'(transactions_done), 32'(rx_count == 32'd16));
      lastRx = int'(rx_count);
    end
  end

  initial begin
    int pushedCnt;
    vecs[0] = '{32'd3, 32'd0,   1'b0};
    vecs[1] = '{32'd3, 32'd1,   1'b0};
    vecs[2] = '{32'd3, 32'd5,   1'b1};
    vecs[3] = '{32'd3, 32'd6,   1'b0};
    vecs[4] = '{32'd7, 32'd7,   1'b1};
    vecs[5] = '{32'd3, 32'd8,   1'b0};
    vecs[6] = '{32'd9, 32'd100, 1'b1};
    vecs[7] = '{32'd3, 32'd101, 1'b0};

    rst = 1'b1; enable = 1'b0; drain_en = 1'b0; data_vld = 1'b0;
    data = '0; cpu_index = 32'd3;
    doReset();

    @(negedge clk);
    checkOutput("idleRdy", 32'(data_rdy), 32'd0);

    // In-order stream with free draining.
    enable = 1'b1; drain_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) applyStimulus(32'd3, 32'(i), 1'b0);
    waitRx(16);
    @(negedge clk);
    checkOutput("streamErr", 32'(error_count), 32'd0);
    checkOutput("streamDone", 32'(transactions_done), 32'd1);
    checkOutput("lateBefore", 32'(late_data), 32'd0);

    // Word offered after completion.
    data = {32'd3, 32'd16};
    data_vld = 1'b1;
    #1 checkOutput("doneRdy", 32'(data_rdy), 32'd0);
    @(negedge clk);
    data_vld = 1'b0;
    checkOutput("lateSet", 32'(late_data), 32'd1);
    checkOutput("lateRx", rx_count, 32'd16);

    // Backpressure: no draining, valid held high.
    doReset();
    enable = 1'b1; drain_en = 1'b0;
    @(negedge clk);
    pushedCnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k >= 4) checkOutput("bpRdyLow", 32'(data_rdy), 32'd0);
      data = {32'd3, 32'(pushedCnt)};
      data_vld = 1'b1;
      if (data_rdy) begin
        expQ.push_back(1'b0);
        pushedCnt++;
      end
      @(negedge clk);
    end
    checkOutput("bpPushes", 32'(pushedCnt), 32'd4);
    checkOutput("bpRxHeld", rx_count, 32'd0);
    drain_en = 1'b1;
    for (int s = pushedCnt; s < 16; s++) applyStimulus(32'd3, 32'(s), 1'b0);
    waitRx(16);
    @(negedge clk);
    checkOutput("bpErr", 32'(error_count), 32'd0);
    checkOutput("bpDone", 32'(transactions_done), 32'd1);

    // Sequence gaps and index mismatches.
    doReset();
    enable = 1'b1; drain_en = 1'b1;
    @(negedge clk);
    for (int v = 0; v < 8; v++) applyStimulus(vecs[v].idx, vecs[v].seq, vecs[v].expErr);
    waitRx(8);
    @(negedge clk);
    checkOutput("tableErrs", 32'(error_count), 32'd3);
    checkOutput("tableDone", 32'(transactions_done), 32'd0);

    // Reset while words are buffered, then a clean restart from seq 0.
    drain_en = 1'b0;
    for (int b = 0; b < 3; b++) applyStimulus(32'd3, 32'(8 + b), 1'b0);
    doReset();
    enable = 1'b1; drain_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) applyStimulus(32'd3, 32'(i), 1'b0);
    waitRx(16);
    @(negedge clk);
    checkOutput("restartErr", 32'(error_count), 32'd0);
    checkOutput("restartDone", 32'(transactions_done), 32'd1);
    checkOutput("restartLate", 32'(late_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
